pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined CPU; it replaces the fixed EX/MEM/WB forwarding flags and the load-use/jump bubble logic in the pipeline top.
- Keeps a shadow scoreboard of in-flight instructions (slot 1 = EX … slot DEPTH = WB).
- Decides stall, bubble and flush for the instruction in ID, and issues registered forwarding selects that travel with that instruction into EX.
- Adds multi-cycle load latency, a halt/drain FSM and a stall counter.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/hazard_match.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline hazard/forwarding control.
// Contents: halt FSM state, scoreboard slot record, forwarding select encoding,
//           opcode constants used by the decoder that feeds the id_* signals.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hstate_t;

  // Slot destination field is sized for the widest supported register
  // address; narrower ADDR_W values are zero-extended on entry.
  localparam int SLOT_DST_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [SLOT_DST_W-1:0] dst;
    logic                  is_load;
  } slot_t;

  // Forwarding select meaning "take the regfile / ID_EX operand".
  localparam int FSEL_NONE = 0;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source register over the in-flight slots.
// Ports: slots (slot 1 = EX .. DEPTH = WB), src/used (consumer source),
//        hit (a producer matches), ready (its result can be forwarded), sel.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FSEL_W   = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH:1]    slots,
  input  logic [ADDR_W-1:0]  src,
  input  logic               used,
  output logic               hit,
  output logic               ready,
  output logic [FSEL_W-1:0]  sel
);

  // Scan oldest to youngest so the youngest match is the one left standing.
  // sel is the slot the producer will occupy once the consumer reaches EX;
  // a producer already in the last slot writes the regfile first, so sel 0.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = FSEL_W'(FSEL_NONE);
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (src != '0) && slots[k].valid && slots[k].wen &&
          (slots[k].dst == SLOT_DST_W'(src))) begin
        hit   = 1'b1;
        ready = (k + 1) >= (slots[k].is_load ? (LOAD_LAT + 2) : 2);
        sel   = (k < DEPTH) ? FSEL_W'(k + 1) : FSEL_W'(FSEL_NONE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: scoreboard of in-flight instructions,
// load-use stall / redirect flush decisions, registered forwarding selects,
// halt/drain FSM and saturating stall counter.
// Ports: Clk/Clr (sync active-high), id_* describe the ID instruction,
//        ex_redirect kills ID; outputs stall/bubble/flush (comb), rest registered.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int FSEL_W   = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              id_halt,
  input  logic              ex_redirect,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic [FSEL_W-1:0] fwd_sel_rs,
  output logic [FSEL_W-1:0] fwd_sel_rt,
  output logic              halted,
  output logic [2:0]        inflight,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t [DEPTH:1] slots;
  slot_t [DEPTH:1] slots_nxt;
  hstate_t         state;

  logic              rs_hit, rs_rdy, rt_hit, rt_rdy;
  logic [FSEL_W-1:0] rs_sel, rt_sel;
  logic              run, lu_stall, accept, drained;
  logic [2:0]        inflight_nxt;

  hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W))
    u_match_rs (.slots(slots), .src(id_rs), .used(id_rs_used),
                .hit(rs_hit), .ready(rs_rdy), .sel(rs_sel));

  hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FSEL_W(FSEL_W))
    u_match_rt (.slots(slots), .src(id_rt), .used(id_rt_used),
                .hit(rt_hit), .ready(rt_rdy), .sel(rt_sel));

  assign run      = (state == RUN);
  assign lu_stall = id_valid & run & ((rs_hit & ~rs_rdy) | (rt_hit & ~rt_rdy));
  assign accept   = id_valid & run & ~lu_stall & ~ex_redirect;

  // A redirect kills the ID instruction, so it overrides a load-use stall.
  // Once halting, the front end stays frozen regardless.
  assign stall_if_id = ~Clr & ((lu_stall & ~ex_redirect) | ~run);
  assign bubble_ex   = ~Clr & (lu_stall | ex_redirect | ~run);
  assign flush_if_id = ~Clr & ex_redirect;

  always_comb begin
    slots_nxt = '0;
    if (accept) begin
      slots_nxt[1] = '{valid: 1'b1, wen: id_wen, dst: SLOT_DST_W'(id_dst),
                       is_load: id_is_load};
    end
    for (int k = 2; k <= DEPTH; k++) begin
      slots_nxt[k] = slots[k-1];
    end
  end

  always_comb begin
    inflight_nxt = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      inflight_nxt = inflight_nxt + {2'b00, slots_nxt[k].valid};
    end
  end

  // During DRAIN nothing enters slot 1, so everything is gone after this
  // edge exactly when slots 1..DEPTH-1 are already empty.
  always_comb begin
    drained = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      if (slots[k].valid) drained = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      slots      <= '0;
      state      <= RUN;
      fwd_sel_rs <= '0;
      fwd_sel_rt <= '0;
      halted     <= 1'b0;
      inflight   <= '0;
      stall_cnt  <= '0;
    end else begin
      slots      <= slots_nxt;
      inflight   <= inflight_nxt;
      fwd_sel_rs <= accept ? rs_sel : FSEL_W'(FSEL_NONE);
      fwd_sel_rt <= accept ? rt_sel : FSEL_W'(FSEL_NONE);
      if (lu_stall && !ex_redirect && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (accept && id_halt) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a DEPTH=3/LOAD_LAT=1 instance driven from a
// vector table, plus a DEPTH=5/LOAD_LAT=3 instance for the long load case.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr;

  // Instance A: DEPTH 3, LOAD_LAT 1
  logic       a_valid, a_rsu, a_rtu, a_wen, a_ld, a_hlt, a_redir;
  logic [4:0] a_rs, a_rt, a_dst;
  logic       a_stall, a_bub, a_flush, a_halted;
  logic [1:0] a_srs, a_srt;
  logic [2:0] a_inf;
  logic [15:0] a_cnt;

  // Instance B: DEPTH 5, LOAD_LAT 3
  logic       b_valid, b_rsu, b_rtu, b_wen, b_ld, b_hlt, b_redir;
  logic [4:0] b_rs, b_rt, b_dst;
  logic       b_stall, b_bub, b_flush, b_halted;
  logic [2:0] b_srs, b_srt;
  logic [2:0] b_inf;
  logic [15:0] b_cnt;

  pipe_hazard_ctrl #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .Clk(clk), .Clr(clr), .id_valid(a_valid), .id_rs(a_rs), .id_rt(a_rt),
    .id_rs_used(a_rsu), .id_rt_used(a_rtu), .id_dst(a_dst), .id_wen(a_wen),
    .id_is_load(a_ld), .id_halt(a_hlt), .ex_redirect(a_redir),
    .stall_if_id(a_stall), .bubble_ex(a_bub), .flush_if_id(a_flush),
    .fwd_sel_rs(a_srs), .fwd_sel_rt(a_srt), .halted(a_halted),
    .inflight(a_inf), .stall_cnt(a_cnt));

  pipe_hazard_ctrl #(.ADDR_W(5), .DEPTH(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
    .Clk(clk), .Clr(clr), .id_valid(b_valid), .id_rs(b_rs), .id_rt(b_rt),
    .id_rs_used(b_rsu), .id_rt_used(b_rtu), .id_dst(b_dst), .id_wen(b_wen),
    .id_is_load(b_ld), .id_halt(b_hlt), .ex_redirect(b_redir),
    .stall_if_id(b_stall), .bubble_ex(b_bub), .flush_if_id(b_flush),
    .fwd_sel_rs(b_srs), .fwd_sel_rt(b_srt), .halted(b_halted),
    .inflight(b_inf), .stall_cnt(b_cnt));

  typedef struct {
    logic       valid;
    logic [4:0] rs, rt;
    logic       rsu, rtu;
    logic [4:0] dst;
    logic       wen, ld, hl, rd;
    logic       es, eb, ef;   // expected comb outputs this cycle
    int         srs, srt, cnt, inf;
    logic       eh;           // expected registered outputs after the edge
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int n;

  function automatic vec_t v(input int vl, rs, rt, rsu, rtu, dst, wen, ld, hl, rd,
                             es, eb, ef, srs, srt, cnt, inf, eh);
    vec_t x;
    x.valid = (vl != 0); x.rs = 5'(rs); x.rt = 5'(rt);
    x.rsu = (rsu != 0); x.rtu = (rtu != 0); x.dst = 5'(dst);
    x.wen = (wen != 0); x.ld = (ld != 0); x.hl = (hl != 0); x.rd = (rd != 0);
    x.es = (es != 0); x.eb = (eb != 0); x.ef = (ef != 0);
    x.srs = srs; x.srt = srt; x.cnt = cnt; x.inf = inf; x.eh = (eh != 0);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t x);
    a_valid = x.valid; a_rs = x.rs; a_rt = x.rt; a_rsu = x.rsu; a_rtu = x.rtu;
    a_dst = x.dst; a_wen = x.wen; a_ld = x.ld; a_hlt = x.hl; a_redir = x.rd;
  endtask

  task automatic idle_b();
    b_valid = 0; b_rs = 0; b_rt = 0; b_rsu = 0; b_rtu = 0;
    b_dst = 0; b_wen = 0; b_ld = 0; b_hlt = 0; b_redir = 0;
  endtask

  initial begin
    //            vl rs rt su tu dst wn ld hl rd  st bu fl  srs srt cnt inf hlt
    vecs[0]  = v(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0); // add $3,$1,$2
    vecs[1]  = v(1, 3, 5, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0,  2, 0, 0, 2, 0); // sub $4,$3,$5
    vecs[2]  = v(1, 0, 4, 1, 0, 6, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0, 3, 0); // lw $6 (rt unused)
    vecs[3]  = v(1, 6, 6, 1, 1, 7, 1, 0, 0, 0,  1, 1, 0,  0, 0, 1, 2, 0); // add $7,$6,$6 stalls
    vecs[4]  = v(1, 6, 6, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0,  3, 3, 1, 2, 0); // then forwards
    vecs[5]  = v(1, 1, 2, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 2, 0); // add $0,$1,$2
    vecs[6]  = v(1, 0, 0, 1, 1, 8, 1, 0, 0, 0,  0, 0, 0,  0, 0, 1, 3, 0); // add $8,$0,$0
    vecs[7]  = v(1, 7, 8, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0,  0, 2, 1, 3, 0); // $7 in last slot
    vecs[8]  = v(1, 9, 8, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0,  2, 3, 1, 3, 0);
    vecs[9]  = v(1, 9, 8, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0,  2, 0, 1, 3, 0); // youngest $9 wins
    vecs[10] = v(1, 0, 0, 1, 0, 11, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0); // lw $11
    vecs[11] = v(1, 11, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1,  0, 0, 1, 2, 0); // halt+stall+redirect
    vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 1, 0);
    vecs[13] = v(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
    vecs[14] = v(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0);
    vecs[15] = v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 1, 3, 0); // halt accepted
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1, 2, 0); // drain
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1, 1, 0);
    vecs[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 1, 0, 1); // 3rd edge: halted
    vecs[19] = v(1, 1, 2, 1, 1, 14, 1, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 1); // ignored when halted

    // Reset: comb outputs stay low under Clr even with a redirect present.
    clr = 1'b1;
    drive_a(v(1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    idle_b();
    @(posedge clk); @(posedge clk); #1;
    chk("rst stall", 32'(a_stall), 0);
    chk("rst bubble", 32'(a_bub), 0);
    chk("rst flush", 32'(a_flush), 0);
    chk("rst sel_rs", 32'(a_srs), 0);
    chk("rst sel_rt", 32'(a_srt), 0);
    chk("rst cnt", 32'(a_cnt), 0);
    chk("rst inflight", 32'(a_inf), 0);
    chk("rst halted", 32'(a_halted), 0);
    clr = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive_a(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(a_stall), 32'(vecs[i].es));
      chk($sformatf("v%0d bubble", i), 32'(a_bub), 32'(vecs[i].eb));
      chk($sformatf("v%0d flush", i), 32'(a_flush), 32'(vecs[i].ef));
      @(posedge clk); #1;
      chk($sformatf("v%0d sel_rs", i), 32'(a_srs), 32'(vecs[i].srs));
      chk($sformatf("v%0d sel_rt", i), 32'(a_srt), 32'(vecs[i].srt));
      chk($sformatf("v%0d cnt", i), 32'(a_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d inflight", i), 32'(a_inf), 32'(vecs[i].inf));
      chk($sformatf("v%0d halted", i), 32'(a_halted), 32'(vecs[i].eh));
    end

    // Clr pulse out of HALTED.
    drive_a(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr halted", 32'(a_halted), 0);
    chk("clr inflight", 32'(a_inf), 0);
    chk("clr cnt", 32'(a_cnt), 0);
    #1;
    chk("clr stall", 32'(a_stall), 0);

    // Long load on the DEPTH 5 / LOAD_LAT 3 instance.
    b_valid = 1; b_rs = 0; b_rsu = 1; b_rt = 0; b_rtu = 0;
    b_dst = 6; b_wen = 1; b_ld = 1;
    #1;
    chk("b lw stall", 32'(b_stall), 0);
    @(posedge clk); #1;
    b_rs = 6; b_rt = 6; b_rtu = 1; b_dst = 7; b_ld = 0;
    #1;
    n = 0;
    while (b_stall && n < 10) begin
      chk($sformatf("b stall%0d bubble", n), 32'(b_bub), 1);
      n++;
      @(posedge clk); #1;
    end
    chk("b stall cycles", 32'(n), 3);
    @(posedge clk); #1;
    idle_b();
    chk("b sel_rs", 32'(b_srs), 5);
    chk("b sel_rt", 32'(b_srt), 5);
    chk("b cnt", 32'(b_cnt), 3);
    chk("b inflight", 32'(b_inf), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
